// File: rtl/hyperram_pkg.sv
// Shared constants, types and CR0 encoding helpers for the HyperRAM configuration front-end.
package hyperram_pkg;

    localparam logic [31:0] CR0_ADDR = 32'h8000_0800;
    localparam logic [31:0] ID0_ADDR = 32'h8000_0000;

    typedef enum logic [2:0] {
        POR_ST,
        CFG_WR_ST,
        ID_RD_ST,
        ID_WAIT_ST,
        CR_RD_ST,
        CR_WAIT_ST,
        READY_ST
    } cfg_state_t;

    typedef struct packed {
        logic        write;
        logic        read;
        logic [31:0] address;
        logic [15:0] writedata;
        logic [1:0]  byteenable;
        logic [7:0]  burstcount;
    } avm_cmd_t;

    // CR0[7:4] initial-latency encoding as defined by the HyperRAM device.
    function automatic logic [3:0] latency_code(input int latency);
        case (latency)
            3:       return 4'b1110;
            4:       return 4'b1111;
            5:       return 4'b0000;
            6:       return 4'b0001;
            7:       return 4'b0010;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [15:0] cr0_word(input int latency, input logic fixed_lat);
        return {1'b1, 3'b000, 4'b1111, latency_code(latency), fixed_lat, 1'b1, 2'b11};
    endfunction

endpackage

// File: rtl/hyperram_por_timer.sv
// Power-up delay: counts LOAD-1 down to 0 after reset release, then pulses done_o once.
module hyperram_por_timer #(
    parameter int LOAD = 15000
) (
    input  logic clk_i,
    input  logic rstn_i,
    output logic done_o
);

    localparam int               CNT_W   = (LOAD > 1) ? $clog2(LOAD) : 1;
    localparam logic [CNT_W-1:0] LOAD_M1 = CNT_W'(LOAD - 1);

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt     <= LOAD_M1;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign done_o = running && (cnt == '0);

endmodule

// File: rtl/hyperram_config.sv
// Avalon-MM stage ahead of hyperram_ctrl: waits out power-up, programs and verifies CR0,
// captures ID0, then becomes a zero-latency pass-through.
module hyperram_config
    import hyperram_pkg::*;
#(
    parameter int G_LATENCY        = 4,
    parameter int G_FIXED_LATENCY  = 1,
    parameter int G_POWERUP_CYCLES = 15000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        s_avm_write_i,
    input  logic        s_avm_read_i,
    input  logic [31:0] s_avm_address_i,
    input  logic [15:0] s_avm_writedata_i,
    input  logic [1:0]  s_avm_byteenable_i,
    input  logic [7:0]  s_avm_burstcount_i,
    output logic [15:0] s_avm_readdata_o,
    output logic        s_avm_readdatavalid_o,
    output logic        s_avm_waitrequest_o,
    output logic        m_avm_write_o,
    output logic        m_avm_read_o,
    output logic [31:0] m_avm_address_o,
    output logic [15:0] m_avm_writedata_o,
    output logic [1:0]  m_avm_byteenable_o,
    output logic [7:0]  m_avm_burstcount_o,
    input  logic [15:0] m_avm_readdata_i,
    input  logic        m_avm_readdatavalid_i,
    input  logic        m_avm_waitrequest_i,
    output logic        cfg_done_o,
    output logic        cfg_error_o,
    output logic [15:0] id0_o
);

    if (G_LATENCY < 3 || G_LATENCY > 7) begin : g_bad_latency
        $error("hyperram_config: G_LATENCY must be within 3..7");
    end

    localparam logic [15:0] CR0_WORD = cr0_word(G_LATENCY, G_FIXED_LATENCY != 0);

    cfg_state_t state_q, state_d;
    avm_cmd_t   cmd_q, cmd_d;
    logic       por_done;
    logic       done_q, err_q;
    logic [15:0] id0_q;
    logic       ready;

    hyperram_por_timer #(
        .LOAD (G_POWERUP_CYCLES)
    ) u_por_timer (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .done_o (por_done)
    );

    // Command outputs are registered from the next state, so they move only on transitions.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= POR_ST;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            POR_ST:     if (por_done)               state_d = CFG_WR_ST;
            CFG_WR_ST:  if (!m_avm_waitrequest_i)   state_d = ID_RD_ST;
            ID_RD_ST:   if (!m_avm_waitrequest_i)   state_d = ID_WAIT_ST;
            ID_WAIT_ST: if (m_avm_readdatavalid_i)  state_d = CR_RD_ST;
            CR_RD_ST:   if (!m_avm_waitrequest_i)   state_d = CR_WAIT_ST;
            CR_WAIT_ST: if (m_avm_readdatavalid_i)  state_d = READY_ST;
            default:                                state_d = READY_ST;
        endcase
    end

    always_comb begin
        cmd_d = '0;
        case (state_d)
            CFG_WR_ST: begin
                cmd_d.write      = 1'b1;
                cmd_d.address    = CR0_ADDR;
                cmd_d.writedata  = CR0_WORD;
                cmd_d.byteenable = 2'b11;
                cmd_d.burstcount = 8'd1;
            end
            ID_RD_ST, CR_RD_ST: begin
                cmd_d.read       = 1'b1;
                cmd_d.address    = (state_d == ID_RD_ST) ? ID0_ADDR : CR0_ADDR;
                cmd_d.byteenable = 2'b11;
                cmd_d.burstcount = 8'd1;
            end
            default: cmd_d = '0;
        endcase
    end

    // Only the first beat in a wait state is used; later beats find the FSM elsewhere.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            id0_q  <= '0;
        end else begin
            if (state_q == ID_WAIT_ST && m_avm_readdatavalid_i) begin
                id0_q <= m_avm_readdata_i;
            end
            if (state_q == CR_WAIT_ST && m_avm_readdatavalid_i) begin
                err_q  <= (m_avm_readdata_i != CR0_WORD);
                done_q <= 1'b1;
            end
        end
    end

    assign ready = (state_q == READY_ST);

    assign m_avm_write_o      = ready ? s_avm_write_i      : cmd_q.write;
    assign m_avm_read_o       = ready ? s_avm_read_i       : cmd_q.read;
    assign m_avm_address_o    = ready ? s_avm_address_i    : cmd_q.address;
    assign m_avm_writedata_o  = ready ? s_avm_writedata_i  : cmd_q.writedata;
    assign m_avm_byteenable_o = ready ? s_avm_byteenable_i : cmd_q.byteenable;
    assign m_avm_burstcount_o = ready ? s_avm_burstcount_i : cmd_q.burstcount;

    assign s_avm_readdata_o      = ready ? m_avm_readdata_i : 16'h0000;
    assign s_avm_readdatavalid_o = ready & m_avm_readdatavalid_i;
    assign s_avm_waitrequest_o   = ready ? m_avm_waitrequest_i : 1'b1;

    assign cfg_done_o  = done_q;
    assign cfg_error_o = err_q;
    assign id0_o       = id0_q;

endmodule
